// File: rtl/traffic_sensor_conditioner.sv
// Vehicle-sensor conditioning for the traffic-light controller: per lane a 2-FF
// synchroniser, debounce filter, minimum-hold stretcher and saturating arrival counter.

module tsc_lane #(
    parameter int DEB_CYC  = 4,
    parameter int HOLD_CYC = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             raw_i,
    input  logic             clr_cnt_i,
    output logic             pres_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int DEB_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int HOLD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [DEB_W-1:0]  DEB_ZERO  = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic              s1_q;
    logic              s2_q;
    logic              filt_q, filt_d;
    logic [DEB_W-1:0]  deb_q,  deb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              rise_s;
    logic              fall_s;

    // Debounce: the filtered level follows the synced level only after it has
    // disagreed for DEB_CYC consecutive edges; any agreement restarts the count.
    always_comb begin
        filt_d = filt_q;
        deb_d  = DEB_ZERO;
        if (s2_q == filt_q) begin
            deb_d = DEB_ZERO;
        end else if (deb_q == DEB_LAST) begin
            filt_d = s2_q;
            deb_d  = DEB_ZERO;
        end else begin
            deb_d = deb_q + DEB_ONE;
        end
    end

    assign rise_s = filt_d & ~filt_q;
    assign fall_s = ~filt_d & filt_q;

    // Hold stretcher and arrival counter, both driven by filtered-level edges.
    always_comb begin
        hold_d = hold_q;
        cnt_d  = cnt_q;
        if (fall_s) begin
            hold_d = HOLD_LOAD;
        end else if (rise_s) begin
            hold_d = HOLD_ZERO;
        end else if (hold_q != HOLD_ZERO) begin
            hold_d = hold_q - HOLD_ONE;
        end else begin
            hold_d = hold_q;
        end

        if (clr_cnt_i) begin
            cnt_d = CNT_ZERO;
        end else if (rise_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Lane state registers; s1 exists only to resolve metastability on raw_i.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            deb_q  <= DEB_ZERO;
            hold_q <= HOLD_ZERO;
            cnt_q  <= CNT_ZERO;
        end else begin
            s1_q   <= raw_i;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            deb_q  <= deb_d;
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pres_o = filt_q | (hold_q != HOLD_ZERO);
    assign cnt_o  = cnt_q;

endmodule

module traffic_sensor_conditioner #(
    parameter int DEB_CYC  = 4,
    parameter int HOLD_CYC = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             clr_cnt,
    output logic             TA,
    output logic             TB,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    tsc_lane #(
        .DEB_CYC  (DEB_CYC),
        .HOLD_CYC (HOLD_CYC),
        .CNT_W    (CNT_W)
    ) u_lane_a (
        .clk_i     (clk),
        .reset_i   (reset),
        .raw_i     (raw_a),
        .clr_cnt_i (clr_cnt),
        .pres_o    (TA),
        .cnt_o     (cnt_a)
    );

    tsc_lane #(
        .DEB_CYC  (DEB_CYC),
        .HOLD_CYC (HOLD_CYC),
        .CNT_W    (CNT_W)
    ) u_lane_b (
        .clk_i     (clk),
        .reset_i   (reset),
        .raw_i     (raw_b),
        .clr_cnt_i (clr_cnt),
        .pres_o    (TB),
        .cnt_o     (cnt_b)
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner: a history-window model checked every
// cycle against two instances (HOLD_CYC=8 and HOLD_CYC=0), plus literal edge checks.

module tb_traffic_sensor_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int CW   = 8;
    localparam int CMAX = 255;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, raw_a, raw_b, clr_cnt;
    logic ta_h8, tb_h8, ta_h0, tb_h0;
    logic [CW-1:0] ca_h8, cb_h8, ca_h0, cb_h0;

    traffic_sensor_conditioner #(.DEB_CYC(DEB), .HOLD_CYC(HOLD), .CNT_W(CW)) u_h8 (
        .clk(clk), .reset(reset), .raw_a(raw_a), .raw_b(raw_b), .clr_cnt(clr_cnt),
        .TA(ta_h8), .TB(tb_h8), .cnt_a(ca_h8), .cnt_b(cb_h8)
    );

    traffic_sensor_conditioner #(.DEB_CYC(DEB), .HOLD_CYC(0), .CNT_W(CW)) u_h0 (
        .clk(clk), .reset(reset), .raw_a(raw_a), .raw_b(raw_b), .clr_cnt(clr_cnt),
        .TA(ta_h0), .TB(tb_h0), .cnt_a(ca_h0), .cnt_b(cb_h0)
    );

    int total = 0;
    int bad   = 0;
    int edge_n = -1;

    // Model channels: 0=A/hold8, 1=B/hold8, 2=A/hold0, 3=B/hold0.
    bit m_filt [4];
    int m_age  [4];
    int m_cnt  [4];
    bit m_hist [4][$];

    function automatic int m_hold(int ch);
        return (ch < 2) ? HOLD : 0;
    endfunction

    function automatic bit m_ta(int ch);
        return m_filt[ch] || (m_age[ch] < m_hold(ch));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            m_filt[ch] = 1'b0;
            m_age[ch]  = NEVER;
            m_cnt[ch]  = 0;
            m_hist[ch].delete();
            for (int i = 0; i < DEB + 2; i++) m_hist[ch].push_back(1'b0);
        end
    endtask

    // History holds raw samples of edges n-DEB-2 .. n-1; entries 1..DEB are the
    // synced levels seen on the last DEB edges. Filter flips when all disagree.
    task automatic model_edge();
        for (int ch = 0; ch < 4; ch++) begin
            bit raw, all_diff, prev;
            raw = (ch % 2 == 0) ? raw_a : raw_b;
            all_diff = 1'b1;
            for (int i = 1; i <= DEB; i++)
                if (m_hist[ch][i] == m_filt[ch]) all_diff = 1'b0;
            prev = m_filt[ch];
            if (all_diff) m_filt[ch] = ~m_filt[ch];
            if (prev && !m_filt[ch]) m_age[ch] = 0;
            else if (!prev && m_filt[ch]) m_age[ch] = NEVER;
            else if (m_age[ch] < NEVER) m_age[ch]++;
            if (clr_cnt) m_cnt[ch] = 0;
            else if (!prev && m_filt[ch] && m_cnt[ch] < CMAX) m_cnt[ch]++;
            m_hist[ch].push_back(raw);
            void'(m_hist[ch].pop_front());
        end
    endtask

    // One clock: model advances at the rising edge, all outputs compared at the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            model_reset();
            edge_n = -1;
        end else begin
            model_edge();
            edge_n++;
        end
        @(negedge clk);
        chk("ta_h8",   ta_h8, m_ta(0));
        chk("tb_h8",   tb_h8, m_ta(1));
        chk("cnta_h8", ca_h8, m_cnt[0]);
        chk("cntb_h8", cb_h8, m_cnt[1]);
        chk("ta_h0",   ta_h0, m_ta(2));
        chk("tb_h0",   tb_h0, m_ta(3));
        chk("cnta_h0", ca_h0, m_cnt[2]);
        chk("cntb_h0", cb_h0, m_cnt[3]);
    endtask

    task automatic run_to(input int e);
        int guard;
        guard = 0;
        while (edge_n < e && guard < 2000) begin
            step();
            guard++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    int bounce_len [12] = '{1, 2, 3, 5, 2, 4, 1, 6, 3, 3, 9, 1};

    initial begin
        bit seen;
        reset = 1'b1; raw_a = 1'b0; raw_b = 1'b0; clr_cnt = 1'b0;
        do_reset();
        chk("reset_ta", ta_h8, 0);
        chk("reset_cnt", ca_h8, 0);

        // Clean arrival then departure: latency 5 edges in, 13 edges out (5 without hold).
        raw_a = 1'b1;
        run_to(4);  chk("t1_ta_e4", ta_h8, 0);
        run_to(5);  chk("t1_ta_e5", ta_h8, 1); chk("t1_cnt", ca_h8, 1);
        chk("t1_tb", tb_h8, 0); chk("t1_cntb", cb_h8, 0);
        run_to(19); raw_a = 1'b0;
        run_to(24); chk("t3_h0_ta_e24", ta_h0, 1);
        run_to(25); chk("t3_h0_ta_e25", ta_h0, 0); chk("t3_h8_ta_e25", ta_h8, 1);
        run_to(32); chk("t3_ta_e32", ta_h8, 1);
        run_to(33); chk("t3_ta_e33", ta_h8, 0);
        run_to(40);

        // Glitches: 3-cycle pulse is swallowed, 4-cycle pulse gets through.
        do_reset();
        raw_a = 1'b1;
        seen = 1'b0;
        while (edge_n < 15) begin
            if (edge_n == 2) raw_a = 1'b0;
            step();
            if (ta_h8) seen = 1'b1;
        end
        chk("t2_glitch_ta", seen, 0);
        chk("t2_glitch_cnt", ca_h8, 0);
        do_reset();
        raw_a = 1'b1;
        run_to(3);  raw_a = 1'b0;
        run_to(4);  chk("t2_p4_ta_e4", ta_h8, 0);
        run_to(5);  chk("t2_p4_ta_e5", ta_h8, 1); chk("t2_p4_cnt", ca_h8, 1);
        run_to(20);

        // Bouncy inputs on both lanes, checked by the model only.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            raw_b = ~raw_b;
            if (bounce_len[i] > 2) raw_a = ~raw_a;
            repeat (bounce_len[i]) step();
        end
        raw_a = 1'b0; raw_b = 1'b0;
        repeat (20) step();

        // Re-arrival inside the hold window keeps TA high continuously.
        do_reset();
        raw_a = 1'b1;
        run_to(19); raw_a = 1'b0;
        while (edge_n < 40) begin
            if (edge_n == 27) raw_a = 1'b1;
            step();
            chk("t4_ta_high", ta_h8, 1);
            if (edge_n == 32) chk("t4_cnt_e32", ca_h8, 1);
            if (edge_n == 33) chk("t4_cnt_e33", ca_h8, 2);
        end
        raw_a = 1'b0;
        run_to(53); chk("t4_ta_e53", ta_h8, 1);
        run_to(54); chk("t4_ta_e54", ta_h8, 0);

        // Saturation after 260 arrivals (B gets every other one), then clear on a rise.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            raw_a = 1'b1; raw_b = (i % 2 == 0);
            repeat (6) step();
            raw_a = 1'b0; raw_b = 1'b0;
            repeat (6) step();
        end
        chk("t5_sat_a", ca_h8, 255);
        chk("t5_b130", cb_h8, 130);
        raw_a = 1'b1;
        repeat (5) step();
        chk("t5_pre_clr", ca_h8, 255);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("t5_clr_rise", ca_h8, 0);
        chk("t5_clr_b", cb_h8, 0);
        repeat (4) step();
        chk("t5_clr_hold", ca_h8, 0);
        raw_a = 1'b0; repeat (6) step();
        raw_a = 1'b1; repeat (6) step();
        chk("t5_after_clr", ca_h8, 1);

        // Mid-operation reset with the sensor still high.
        do_reset();
        raw_a = 1'b1; raw_b = 1'b0;
        run_to(10); chk("t6_pre_ta", ta_h8, 1);
        do_reset();
        chk("t6_rst_ta", ta_h8, 0);
        chk("t6_rst_cnt", ca_h8, 0);
        run_to(4); chk("t6_ta_e4", ta_h8, 0);
        run_to(5); chk("t6_ta_e5", ta_h8, 1); chk("t6_cnt", ca_h8, 1);
        run_to(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
